// File: rtl/baud_pkg.sv
// Shared definitions for the programmable baud tick generator.
//   calc_inc  : reset-time phase increment, round(baud*os*2^acc_w / clk_freq),
//               evaluated in 64-bit arithmetic at elaboration time.
//   ph_width  : phase counter width, max(1, $clog2(os)); users declare
//               typedef logic [ph_width(OS)-1:0] phase_t locally.
//   mode_e    : per-cycle control decode (enable > sync > count).
package baud_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_SYNC  = 2'd1,
    MODE_COUNT = 2'd2
  } mode_e;

  function automatic int ph_width(input int os);
    return (os > 2) ? $clog2(os) : 1;
  endfunction

  function automatic logic [63:0] calc_inc(input logic [63:0] clk_freq,
                                           input logic [63:0] baud,
                                           input logic [63:0] os,
                                           input int          acc_w);
    logic [63:0] num;
    num = baud * os * (64'd1 << acc_w);
    return (num + (clk_freq >> 1)) / clk_freq;
  endfunction

endpackage

// File: rtl/frac_phase_acc.sv
// Fractional phase accumulator.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clear the accumulator instead of advancing it
//   inc_i     : ACC_W-bit phase increment
//   carry_o   : carry out of acc + inc for the current cycle (combinational)
// The sum is one bit wider than the accumulator so a carry is never lost.
module frac_phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_i};
    carry_o = sum[ACC_W];
    acc_d   = clr_i ? '0 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_tick_gen_prog.sv
// Runtime-programmable fractional baud tick generator.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : run generator; low clears phase and ticks
//   inc_wr     : load inc_in into the increment register (any non-reset cycle)
//   inc_in     : new increment, tick rate = CLK_FREQ*inc/2^ACC_W
//   sync       : restart phase at mid-bit (receiver start-bit lock)
//   os_tick    : registered one-cycle oversample tick
//   bit_tick   : registered one-cycle bit tick, every OVERSAMPLING os_ticks
//   half_tick  : registered mid-bit tick when BAUD_GEN_HALF_TICK_EN is defined,
//                constant 0 otherwise
//   inc_q      : current increment, for readback
// Optional feature macro: BAUD_GEN_HALF_TICK_EN
module baud_tick_gen_prog
  import baud_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 16,
  parameter int ACC_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             inc_wr,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             sync,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             half_tick,
  output logic [ACC_W-1:0] inc_q
);

  localparam int PH_W = ph_width(OVERSAMPLING);
  typedef logic [PH_W-1:0] phase_t;

  localparam logic [ACC_W-1:0] DEFAULT_INC =
    ACC_W'(calc_inc(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLING), ACC_W));
  localparam phase_t PH_LAST = phase_t'(OVERSAMPLING - 1);
  // Mid-bit restart point; with one os_tick per bit the phase stays at 0.
  localparam phase_t PH_SYNC =
    phase_t'((OVERSAMPLING - OVERSAMPLING / 2) % OVERSAMPLING);

  mode_e            mode;
  logic             carry;
  logic [ACC_W-1:0] inc_d;
  phase_t           phase_q, phase_d;
  logic             os_q, os_d;
  logic             bit_q, bit_d;

  always_comb begin
    if (!enable)   mode = MODE_IDLE;
    else if (sync) mode = MODE_SYNC;
    else           mode = MODE_COUNT;
  end

  // ---- stage p0: phase accumulation ----
  frac_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mode != MODE_COUNT),
    .inc_i   (inc_q),
    .carry_o (carry)
  );

  always_comb begin
    inc_d   = inc_wr ? inc_in : inc_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    bit_d   = 1'b0;
    unique case (mode)
      MODE_IDLE: phase_d = '0;
      MODE_SYNC: phase_d = PH_SYNC;
      default: begin
        os_d  = carry;
        bit_d = carry && (phase_q == PH_LAST);
        if (carry) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + phase_t'(1);
      end
    endcase
  end

  // ---- stage p1: registered ticks ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q   <= DEFAULT_INC;
      phase_q <= '0;
      os_q    <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      phase_q <= phase_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
    end
  end

  assign os_tick  = os_q;
  assign bit_tick = bit_q;

`ifdef BAUD_GEN_HALF_TICK_EN
  // With one os_tick per bit the mid-bit strobe collapses onto bit_tick.
  localparam phase_t PH_HALF =
    (OVERSAMPLING == 1) ? '0 : phase_t'(OVERSAMPLING / 2 - 1);

  logic half_q, half_d;

  always_comb begin
    half_d = (mode == MODE_COUNT) && carry && (phase_q == PH_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) half_q <= 1'b0;
    else     half_q <= half_d;
  end

  assign half_tick = half_q;
`else
  assign half_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Bench for baud_tick_gen_prog (default parameters). A cycle-level reference
// model built from modular phase arithmetic predicts every output each cycle;
// directed sequences check reset defaults, long-run tick counts, sync and
// enable realignment, run-time rate change, async reset and boundary rates.
module tb_baud_tick_gen_prog;

  localparam int CLK_FREQ     = 12000000;
  localparam int BAUD         = 115200;
  localparam int OS           = 16;
  localparam int ACC_W        = 16;
  localparam longint MODULUS  = 64'd1 << ACC_W;
  localparam longint DEF_INC  = 10066;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             inc_wr;
  logic [ACC_W-1:0] inc_in;
  logic             sync;
  logic             os_tick, bit_tick, half_tick;
  logic [ACC_W-1:0] inc_q;

  baud_tick_gen_prog #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .OVERSAMPLING (OS),
    .ACC_W        (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .inc_wr    (inc_wr),
    .inc_in    (inc_in),
    .sync      (sync),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .half_tick (half_tick),
    .inc_q     (inc_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: fractional phase in units of 2^-ACC_W of an
  // os_tick period, and count of os_ticks already emitted within the bit.
  longint m_frac;
  int     m_cnt;
  longint m_inc;
  logic   e_os, e_bit, e_half;

  int     cyc, os_cnt, bit_cnt, half_cnt, last_os, max_gap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frac = 0; m_cnt = 0; m_inc = DEF_INC;
    e_os = 0; e_bit = 0; e_half = 0;
  endtask

  task automatic clear_counts();
    os_cnt = 0; bit_cnt = 0; half_cnt = 0; last_os = -1; max_gap = 0;
  endtask

  // One clock: predict with the inputs present at the edge, then compare.
  task automatic step();
    longint total;
    @(posedge clk);
    e_os = 0; e_bit = 0; e_half = 0;
    if (!enable) begin
      m_frac = 0; m_cnt = 0;
    end else if (sync) begin
      m_frac = 0; m_cnt = (OS - OS / 2) % OS;
    end else begin
      total  = m_frac + m_inc;
      m_frac = total % MODULUS;
      if (total >= MODULUS) begin
        e_os  = 1;
        e_bit = (m_cnt == OS - 1);
`ifdef BAUD_GEN_HALF_TICK_EN
        e_half = (m_cnt == (OS / 2 + OS - 1) % OS);
`endif
        m_cnt = (m_cnt + 1) % OS;
      end
    end
    if (inc_wr) m_inc = inc_in;
    #1;
    check("os_tick", os_tick, e_os);
    check("bit_tick", bit_tick, e_bit);
    check("half_tick", half_tick, e_half);
    check("inc_q", inc_q, m_inc);
    cyc++;
    if (os_tick === 1'b1) begin
      os_cnt++;
      if (last_os >= 0 && cyc - last_os > max_gap) max_gap = cyc - last_os;
      last_os = cyc;
    end
    if (bit_tick === 1'b1) bit_cnt++;
    if (half_tick === 1'b1) half_cnt++;
  endtask

  // Count os_ticks up to and including the first bit_tick (or half_tick).
  task automatic count_to(input bit use_half, output int n);
    bit hit;
    n = 0; hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      if (os_tick === 1'b1) n++;
      hit = use_half ? (half_tick === 1'b1) : (bit_tick === 1'b1);
    end
    if (!hit) check("count_to_timeout", 0, 1);
  endtask

  // Called just after an edge: assert reset mid-cycle, check, release.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_half_tick", half_tick, 0);
    check("rst_inc_q", inc_q, DEF_INC);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 0; inc_wr = 0; inc_in = '0; sync = 0;
    cyc = 0;
    clear_counts();
    @(posedge clk);
    #1;
    check("reset_os_tick", os_tick, 0);
    check("reset_bit_tick", bit_tick, 0);
    check("reset_half_tick", half_tick, 0);
    check("reset_inc_q", inc_q, DEF_INC);
    #2 rst = 1'b0;
    model_reset();

    // Default rate over one full accumulator period.
    enable = 1;
    clear_counts();
    repeat (65536) step();
    check("t1_os_count", os_cnt, 10066);
    check("t1_bit_count", bit_cnt, 629);
    check("t1_gap_le_7", max_gap <= 7, 1);

    // Half-rate increment loaded while idle.
    enable = 0; step();
    inc_wr = 1; inc_in = 16'd32768; step();
    inc_wr = 0;
    check("t2_inc_q", inc_q, 32768);
    enable = 1;
    step(); check("t2_first_cycle", os_tick, 0);
    step(); check("t2_first_os", os_tick, 1);
    clear_counts();
    repeat (96) step();
    check("t2_bit_count", bit_cnt, 3);
    check("t2_os_count", os_cnt, 48);

    // Sync mid-stream, including a sync that swallows a carry.
    repeat ($urandom_range(3, 9)) step();
    sync = 1; step(); sync = 0;
    check("t3_sync_os", os_tick, 0);
    check("t3_sync_bit", bit_tick, 0);
    step();
    sync = 1; step(); sync = 0;
    check("t3_sync_carry_os", os_tick, 0);
    count_to(0, n);
    check("t3_os_to_bit", n, 8);

    // Enable dropped mid-bit, then restored.
    repeat (5) step();
    enable = 0; step();
    check("t4_idle_os", os_tick, 0);
    check("t4_idle_bit", bit_tick, 0);
    repeat (4) step();
    enable = 1;
    count_to(0, n);
    check("t4_os_to_bit", n, 16);

    // Rate doubled while running.
    do_reset();
    repeat (300) step();
    inc_wr = 1; inc_in = 16'd20132; step(); inc_wr = 0;
    check("t5_inc_q", inc_q, 20132);
    clear_counts();
    repeat (1000) step();
    check("t5_rate_x2", (os_cnt == 307 || os_cnt == 308), 1);

    // Async reset after a write, then the mid-bit strobe.
    inc_wr = 1; inc_in = 16'd32768; step(); inc_wr = 0;
    repeat (21) step();
    do_reset();
    enable = 0; inc_wr = 1; inc_in = 16'd32768; step();
    inc_wr = 0; enable = 1;
`ifdef BAUD_GEN_HALF_TICK_EN
    count_to(1, n);
    check("t6_os_to_half", n, 8);
`else
    clear_counts();
    repeat (200) step();
    check("t6_half_count", half_cnt, 0);
`endif

    // Boundary increments.
    enable = 0; inc_wr = 1; inc_in = '0; step();
    inc_wr = 0; enable = 1;
    clear_counts();
    repeat (50) step();
    check("b_inc0_os_count", os_cnt, 0);
    enable = 0; inc_wr = 1; inc_in = 16'hFFFF; step();
    inc_wr = 0; enable = 1;
    clear_counts();
    repeat (100) step();
    check("b_incmax_os_count", os_cnt, 99);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      sync   = ($urandom_range(0, 29) == 0);
      inc_wr = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 5))
        0:       inc_in = '0;
        1:       inc_in = 16'hFFFF;
        default: inc_in = ACC_W'($urandom_range(1000, 40000));
      endcase
      step();
    end
    enable = 0; sync = 0; inc_wr = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
